frv_bitwise_mc: RTL

Parametrised, multi-cycle successor to the single-cycle bitwise unit. It implements funnel-shift-left/right, wide rotate-right, conditional move and ternary bitwise-op for an XLEN-bit datapath. Rotates are iterative: a coarse stage moves STEP bits per cycle, and a small fine barrel handles the remainder, trading latency for area on wide configurations. The block sits in the execute stage behind the core's valid/ready functional-unit handshake.

---
 rtl/frv_bitwise_mc.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/frv_bitwise_mc.sv
// frv_bitwise_mc: multi-cycle bitwise unit for the execute stage.
// Funnel shifts (fsl/fsr) and wide rotate (mror) iterate through a fixed
// coarse rotate of STEP bits per cycle plus a log2(STEP)-level fine barrel
// for the remainder. cmov, bop and the no-op case finish in one cycle.
//
// Ports:
//   g_clk, g_resetn      clock; synchronous active-low reset
//   flush                abort any in-flight op (no ready for it)
//   valid / ready        request held until ready; ready is a 1-cycle pulse
//   rs1, rs2, rs3        XLEN-bit source operands (sampled at acceptance only)
//   bop_lut              8-entry truth table for bop
//   uop_fsl..uop_bop     op select, priority fsl > fsr > mror > cmov > bop
//   result               registered 2*XLEN-bit result, held until next load
module frv_bitwise_mc #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 8
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  input  logic                flush,
  input  logic                valid,
  input  logic [XLEN-1:0]     rs1,
  input  logic [XLEN-1:0]     rs2,
  input  logic [XLEN-1:0]     rs3,
  input  logic [7:0]          bop_lut,
  input  logic                uop_fsl,
  input  logic                uop_fsr,
  input  logic                uop_mror,
  input  logic                uop_cmov,
  input  logic                uop_bop,
  output logic [2*XLEN-1:0]   result,
  output logic                ready
);

  localparam int unsigned SW = $clog2(XLEN) + 1;
  localparam int unsigned W2 = 2 * XLEN;
  localparam int unsigned FL = $clog2(STEP);

  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

  state_t          state;
  logic [W2-1:0]   word;
  logic [SW-1:0]   rem;
  logic            left;
  logic            half;

  logic [W2-1:0]   rot_w;
  logic [SW-1:0]   rem_nxt;
  logic [XLEN-1:0] bop_val;
  logic [W2-1:0]   quick_res;
  logic            sel_fs;
  logic            sel_mror;
  logic            sel_cmov;
  logic            sel_bop;

  // Rotate x by a constant k in the given direction.
  function automatic logic [W2-1:0] rot_c(input logic [W2-1:0] x,
                                          input int unsigned k,
                                          input logic to_left);
    if (k == 0) return x;
    if (to_left) return (x << k) | (x >> (W2 - k));
    return (x >> k) | (x << (W2 - k));
  endfunction

  // One iteration: full STEP coarse rotate, or the fine barrel for the tail.
  always_comb begin
    rot_w   = word;
    rem_nxt = '0;
    if (rem >= SW'(STEP)) begin
      rot_w   = rot_c(word, STEP, left);
      rem_nxt = rem - SW'(STEP);
    end else begin
      for (int l = 0; l < int'(FL); l++) begin
        if (((int'(rem) >> l) & 1) != 0) rot_w = rot_c(rot_w, 1 << l, left);
      end
    end
  end

  // Op decode in priority order; fsl and fsr share the funnel datapath.
  always_comb begin
    sel_fs   = uop_fsl | uop_fsr;
    sel_mror = !sel_fs && uop_mror;
    sel_cmov = !sel_fs && !uop_mror && uop_cmov;
    sel_bop  = !sel_fs && !uop_mror && !uop_cmov && uop_bop;
  end

  // Single-cycle ops: cmov, bop, and zero for no op selected.
  always_comb begin
    for (int i = 0; i < int'(XLEN); i++) bop_val[i] = bop_lut[{rs1[i], rs2[i], rs3[i]}];
    quick_res = '0;
    if (sel_cmov)     quick_res = {{XLEN{1'b0}}, ((|rs2) ? rs1 : rs3)};
    else if (sel_bop) quick_res = {{XLEN{1'b0}}, bop_val};
  end

  // Control FSM with registered result and ready.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state  <= IDLE;
      result <= '0;
      ready  <= 1'b0;
      rem    <= '0;
      word   <= '0;
      left   <= 1'b0;
      half   <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (valid) begin
            if (sel_fs) begin
              word  <= {rs1, rs3};
              rem   <= rs2[SW-1:0];
              left  <= uop_fsl;
              half  <= 1'b1;
              state <= ROT;
            end else if (sel_mror) begin
              word  <= {rs1, rs2};
              rem   <= rs3[SW-1:0];
              left  <= 1'b0;
              half  <= 1'b0;
              state <= ROT;
            end else begin
              result <= quick_res;
              ready  <= 1'b1;
              state  <= DONE;
            end
          end
        end
        ROT: begin
          word <= rot_w;
          rem  <= rem_nxt;
          if (rem_nxt == '0) begin
            // Funnel shifts return the upper half of the rotated pair.
            result <= half ? {{XLEN{1'b0}}, rot_w[W2-1:XLEN]} : rot_w;
            ready  <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          ready <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
